// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared AXI4-Lite constants and the command-master state type.
//   C_RESP_*           : bresp/rresp encodings
//   C_AXI_PROT_DEFAULT : awprot/arprot value driven by the master
//   t_axi_master_state : command-master FSM states
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;
  localparam logic [1:0] C_RESP_DECERR = 2'b11;

  localparam logic [2:0] C_AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } t_axi_master_state;

endpackage

// File: rtl/axi4_lite_master_cmd.sv
// -----------------------------------------------------------------------------
// axi4_lite_master_cmd
// Single-outstanding AXI4-Lite initiator driven by a one-beat command port.
//
// Optional build macro: AXI4_LITE_MASTER_TIMEOUT_EN
//   defined   : per-wait-state watchdog, expiry completes with SLVERR + o_timeout
//   undefined : no watchdog, o_timeout tied low, waits indefinitely
//
// Ports
//   clk_sys, rst_sys              : clock, synchronous active-high reset
//   i_start/i_wr_rd/i_addr/
//   i_wdata/i_wstrb               : command (sampled in IDLE only)
//   o_busy/o_done/o_rdata/
//   o_resp/o_timeout              : status and results
//   aw*/w*/b*/ar*/r*              : AXI4-Lite master channels
//
// state   | meaning
// IDLE    | waiting for i_start
// WR      | awvalid/wvalid outstanding, each drops after its own handshake
// WR_RESP | bready high, waiting for bvalid
// RD_ADDR | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for rvalid
// DONE    | one-cycle o_done pulse, back to IDLE
// -----------------------------------------------------------------------------
module axi4_lite_master_cmd
  import axi4_lite_pkg::*;
#(
  parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
  parameter int G_AXI4_LITE_DATA_WIDTH = 32,  // 32 or 64
  parameter int G_TIMEOUT_CYCLES       = 1024
) (
  input  logic                                  clk_sys,
  input  logic                                  rst_sys,
  input  logic                                  i_start,
  input  logic                                  i_wr_rd,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     i_addr,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]     i_wdata,
  input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]   i_wstrb,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]     o_rdata,
  output logic [1:0]                            o_resp,
  output logic                                  o_timeout,
  output logic                                  awvalid,
  output logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     awaddr,
  output logic [2:0]                            awprot,
  input  logic                                  awready,
  output logic                                  wvalid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]     wdata,
  output logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]   wstrb,
  input  logic                                  wready,
  output logic                                  bready,
  input  logic                                  bvalid,
  input  logic [1:0]                            bresp,
  output logic                                  arvalid,
  output logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     araddr,
  output logic [2:0]                            arprot,
  input  logic                                  arready,
  output logic                                  rready,
  input  logic                                  rvalid,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                            rresp
);

  localparam int AW = G_AXI4_LITE_ADDR_WIDTH;
  localparam int DW = G_AXI4_LITE_DATA_WIDTH;
  localparam int SW = G_AXI4_LITE_DATA_WIDTH / 8;

  t_axi_master_state state_q, state_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic          bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0]    resp_q, resp_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          aw_hs, w_hs;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(G_TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] C_WD_LAST = CW'(G_TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q, timeout_d;
  logic          waiting;
`endif

  assign aw_hs = awvalid_q & awready;
  assign w_hs  = wvalid_q & wready;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          addr_d  = i_addr;
          wdata_d = i_wdata;
          wstrb_d = i_wstrb;
          busy_d  = 1'b1;
          if (i_wr_rd) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // handshakes of this cycle count, so simultaneous completion skips a cycle
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          resp_d   = bresp;
          bready_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_d  = rdata;
          resp_d   = rresp;
          rready_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    // expiry only fires when the state would not have advanced anyway,
    // which gives a handshake in the expiry cycle priority
    timeout_d = 1'b0;
    wd_cnt_d  = '0;
    waiting   = (state_q == WR) || (state_q == WR_RESP) ||
                (state_q == RD_ADDR) || (state_q == RD_DATA);
    if (waiting && (state_d == state_q)) begin
      if (wd_cnt_q == C_WD_LAST) begin
        state_d   = DONE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        resp_d    = C_RESP_SLVERR;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        timeout_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_rdata = rdata_q;
  assign o_resp  = resp_q;

  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awprot  = C_AXI_PROT_DEFAULT;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = bready_q;
  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arprot  = C_AXI_PROT_DEFAULT;
  assign rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_cmd.sv
module tb_axi4_lite_master_cmd;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        i_start = 1'b0, i_wr_rd = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic [3:0]  i_wstrb = '0;
  logic        o_busy, o_done, o_timeout;
  logic [31:0] o_rdata;
  logic [1:0]  o_resp;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  axi4_lite_master_cmd #(
    .G_AXI4_LITE_ADDR_WIDTH(32), .G_AXI4_LITE_DATA_WIDTH(32), .G_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .i_start(i_start), .i_wr_rd(i_wr_rd),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .o_busy(o_busy),
    .o_done(o_done), .o_rdata(o_rdata), .o_resp(o_resp), .o_timeout(o_timeout),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bready(bready), .bvalid(bvalid), .bresp(bresp),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
    .rready(rready), .rvalid(rvalid), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model (reacts on the falling edge) ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic        aw_have = 0, w_have = 0, ar_have = 0, b_fire = 0, r_fire = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [31:0] slv_mem [logic [31:0]];
  int          n_wr_seen = 0, n_rd_seen = 0;

  always @(negedge clk_sys) begin
    if (rst_sys) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_have = 0; w_have = 0; ar_have = 0; b_fire = 0; r_fire = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (b_fire) begin
        bvalid = 0; b_fire = 0; aw_have = 0; w_have = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else if (aw_have && w_have && !bvalid) begin
        if (b_cnt >= b_dly) begin
          logic [31:0] cur;
          cur = slv_mem.exists(cap_awaddr) ? slv_mem[cap_awaddr] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (cap_wstrb[b]) cur[8*b +: 8] = cap_wdata[8*b +: 8];
          slv_mem[cap_awaddr] = cur;
          bvalid = 1; bresp = cfg_bresp; n_wr_seen++;
        end else b_cnt++;
      end
      if (bvalid && bready) b_fire = 1;

      if (r_fire) begin
        rvalid = 0; r_fire = 0; ar_have = 0; ar_cnt = 0; r_cnt = 0;
      end else if (ar_have && !rvalid) begin
        if (r_cnt >= r_dly) begin
          rdata  = slv_mem.exists(cap_araddr) ? slv_mem[cap_araddr] : 32'h0;
          rresp  = cfg_rresp; rvalid = 1; n_rd_seen++;
        end else r_cnt++;
      end
      if (rvalid && rready) r_fire = 1;

      awready = 0;
      if (awvalid && !aw_have) begin
        if (aw_cnt >= aw_dly) begin awready = 1; aw_have = 1; cap_awaddr = awaddr; end
        else aw_cnt++;
      end
      wready = 0;
      if (wvalid && !w_have) begin
        if (w_cnt >= w_dly) begin wready = 1; w_have = 1; cap_wdata = wdata; cap_wstrb = wstrb; end
        else w_cnt++;
      end
      arready = 0;
      if (arvalid && !ar_have) begin
        if (ar_cnt >= ar_dly) begin arready = 1; ar_have = 1; cap_araddr = araddr; end
        else ar_cnt++;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int          viol = 0, aw_hi_total = 0, w_hi_total = 0, done_total = 0;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_rst = 1;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;

  always @(negedge clk_sys) begin
    #1;
    if (!p_rst && !o_done) begin
      if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) viol++;
      if (p_wv && !p_wr && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) viol++;
      if (p_arv && !p_arr && (!arvalid || araddr !== p_araddr)) viol++;
    end
    if (awprot !== 3'b000 || arprot !== 3'b000) viol++;
    aw_hi_total += int'(awvalid);
    w_hi_total  += int'(wvalid);
    done_total  += int'(o_done);
    p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
    p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
    p_arv = arvalid; p_arr = arready; p_araddr = araddr;
    p_rst = rst_sys;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_rdata = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // Issues one command at a falling edge; returns in the o_done cycle.
  // lat counts cycles from the start cycle to the o_done cycle inclusive.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output int lat, output logic [31:0] rd,
                         output logic [1:0] rsp, output logic to);
    int n;
    i_wr_rd = wr; i_addr = addr; i_wdata = data; i_wstrb = strb; i_start = 1'b1;
    @(negedge clk_sys);
    i_start = 1'b0;
    n = 1;
    check("busy_after_start", o_busy, 1);
    while (!o_done && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check("done_seen", o_done, 1);
    check("busy_low_at_done", o_busy, 0);
    lat = n + 1;
    rd = o_rdata; rsp = o_resp; to = o_timeout;
  endtask

  task automatic do_txn(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input int adl, input int wdl, input int ardl, input int bdl, input int rdl,
                        input logic [1:0] br, input logic [1:0] rr);
    int lat, exp_lat;
    logic [31:0] rd, exp_rd;
    logic [1:0] rsp;
    logic to;
    aw_dly = adl; w_dly = wdl; ar_dly = ardl; b_dly = bdl; r_dly = rdl;
    cfg_bresp = br; cfg_rresp = rr;
    run_txn(wr, addr, data, strb, lat, rd, rsp, to);
    if (wr) begin
      exp_lat = 4 + ((adl > wdl) ? adl : wdl) + bdl;
      ref_mem[addr] = merge(ref_mem.exists(addr) ? ref_mem[addr] : 32'h0, data, strb);
      check({tag, "_rdata_kept"}, rd, ref_rdata);
      check({tag, "_resp"}, rsp, br);
    end else begin
      exp_lat = 4 + ardl + rdl;
      exp_rd = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
      ref_rdata = exp_rd;
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_resp"}, rsp, rr);
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_timeout"}, to, 0);
    @(negedge clk_sys);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int aw0, w0, rd0, d0, lat;
    logic [31:0] rdv;
    logic [1:0] rsp;
    logic to;

    // reset state
    repeat (3) @(negedge clk_sys);
    check("rst_outputs", {o_busy, o_done, o_timeout, awvalid, wvalid, bready, arvalid, rready}, 0);
    check("rst_rdata_resp", {o_rdata, o_resp}, 0);
    check("rst_addr_data", {awaddr, wdata}, 0);
    rst_sys = 1'b0;
    @(negedge clk_sys);

    // zero-wait write
    aw0 = aw_hi_total; w0 = w_hi_total;
    do_txn("zw_wr", 1, 32'h4, 32'h0000_0A55, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    check("zw_awvalid_cycles", aw_hi_total - aw0, 1);
    check("zw_wvalid_cycles", w_hi_total - w0, 1);
    check("zw_slave_reg", slv_mem.exists(32'h4) ? slv_mem[32'h4] : 32'hX, 32'h0000_0A55);

    // backpressure: awready after 3 cycles, wready after 6
    aw0 = aw_hi_total; w0 = w_hi_total;
    do_txn("bp_wr", 1, 32'h10, 32'h1234_5678, 4'hF, 3, 6, 0, 0, 0, 2'b00, 2'b00);
    check("bp_awvalid_cycles", aw_hi_total - aw0, 4);
    check("bp_wvalid_cycles", w_hi_total - w0, 7);

    // slow read of 0xDEADBEEF with SLVERR
    do_txn("rd_prep", 1, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    do_txn("slow_rd", 0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b00, 2'b10);
    check("slow_rd_value", o_rdata, 32'hDEAD_BEEF);

    // busy: a start during a write is dropped; start right after DONE is taken
    #2;
    rd0 = n_rd_seen;
    fork
      do_txn("busy_wr", 1, 32'h14, 32'hA5A5_0001, 4'h3, 4, 2, 0, 1, 0, 2'b00, 2'b00);
      begin
        repeat (2) @(negedge clk_sys);
        i_start = 1'b1; i_wr_rd = 1'b0; i_addr = 32'h40;
        @(negedge clk_sys);
        i_start = 1'b0;
      end
    join
    do_txn("b2b_rd", 0, 32'h14, 32'h0, 4'h0, 0, 0, 1, 0, 0, 2'b00, 2'b01);
    repeat (3) @(negedge clk_sys);
    check("busy_idle_after", {o_busy, arvalid, awvalid}, 0);
    #2;
    check("busy_extra_start_dropped", n_rd_seen - rd0, 1);

    // reset mid-transaction
    @(negedge clk_sys);
    d0 = done_total;
    aw_dly = 1000;
    i_wr_rd = 1'b1; i_addr = 32'h20; i_wdata = 32'hFFFF_FFFF; i_wstrb = 4'hF; i_start = 1'b1;
    @(negedge clk_sys);
    i_start = 1'b0;
    @(negedge clk_sys);
    check("rstmid_aw_pending", awvalid, 1);
    rst_sys = 1'b1;
    @(negedge clk_sys);
    check("rstmid_after", {awvalid, wvalid, o_busy, o_done}, 0);
    @(negedge clk_sys);
    rst_sys = 1'b0;
    repeat (2) @(negedge clk_sys);
    #2;
    check("rstmid_no_done", done_total - d0, 0);
    do_txn("rstmid_rd", 0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    // slave never answers with bvalid
    aw_dly = 0; w_dly = 0; b_dly = 100000;
    run_txn(1'b1, 32'h30, 32'h1, 4'hF, lat, rdv, rsp, to);
    check("to_flag", to, 1);
    check("to_resp", rsp, 2'b10);
    check("to_latency", lat, 3 + TO);
    @(negedge clk_sys);
    rst_sys = 1'b1;
    repeat (2) @(negedge clk_sys);
    rst_sys = 1'b0;
    @(negedge clk_sys);
`endif

    // randomized traffic against the reference model
    for (int k = 0; k < 40; k++) begin
      logic        wr;
      logic [31:0] a, d;
      logic [3:0]  s;
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 7)) << 2;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      do_txn("rnd", wr, a, d, s,
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 3), $urandom_range(0, 4),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    check("protocol_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master_cmd.md
Name: axi4_lite_master_cmd

Overview:
- Synthesizable AXI4-Lite initiator. Converts a simple single-beat command port (start, write/read, address, data, strobe) into AXI4-Lite transactions.
- Counterpart of the axi4_lite_max7219 slave. It lets on-chip logic (sequencer, CPU-less controller) program the MAX7219 register file without a testbench BFM.
- Supports one outstanding transaction; it returns read data and the response code.

Parameters:
- G_AXI4_LITE_ADDR_WIDTH, 32, width of awaddr/araddr and i_addr.
- G_AXI4_LITE_DATA_WIDTH, 32, width of wdata/rdata/i_wdata/o_rdata; must be 32 or 64.
- G_TIMEOUT_CYCLES, 1024, watchdog limit in clk_sys cycles; used only with AXI4_LITE_MASTER_TIMEOUT_EN.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- rst_sys  in  1  reset, synchronous, active-high.
- i_start  in  1  command request, sampled in IDLE only.
- i_wr_rd  in  1  1 = write, 0 = read.
- i_addr  in  ADDR_W  byte address.
- i_wdata  in  DATA_W  write data.
- i_wstrb  in  DATA_W/8  write strobes.
- o_busy  out  1  high from the cycle after start is accepted until the done pulse.
- o_done  out  1  one-cycle pulse, transaction complete.
- o_rdata  out  DATA_W  read data, valid with o_done and held until the next read completes.
- o_resp  out  2  bresp/rresp captured, valid with o_done.
- o_timeout  out  1  watchdog expiry flag, valid with o_done.
- awvalid, awaddr[ADDR_W], awprot[3]  out; awready  in.
- wvalid, wdata[DATA_W], wstrb[DATA_W/8]  out; wready  in.
- bready  out; bvalid  in; bresp[2]  in.
- arvalid, araddr[ADDR_W], arprot[3]  out; arready  in.
- rready  out; rvalid  in; rdata[DATA_W], rresp[2]  in.

Behaviour:
- Reset (rst_sys=1 at a clock edge):
  - State goes to IDLE.
  - All valid/ready outputs go to 0; o_busy, o_done and o_timeout go to 0.
  - o_rdata and o_resp go to 0; address/data output registers go to 0.
- Reset mid-transaction aborts immediately, with no completion pulse.
- awprot and arprot are constant 3'b000.
- IDLE:
  - i_start=1 latches i_addr, i_wdata and i_wstrb into registers.
  - i_wr_rd=1 goes to WR; i_wr_rd=0 goes to RD_ADDR.
  - o_busy=1 from the next cycle.
  - i_start while busy is ignored (not queued).
- WR:
  - awvalid=1 and wvalid=1 are asserted together in the first WR cycle (1 cycle after start).
  - Each valid drops in the cycle after its own handshake (valid & ready). Per-channel done flags track this.
  - Address, data and strobe stay stable while valid.
  - When both channels are done, go to WR_RESP. If both handshake in the same cycle, go directly.
- WR_RESP:
  - bready=1.
  - On bvalid: capture bresp into o_resp, drop bready, go to DONE.
- RD_ADDR: arvalid=1 until arready; on handshake go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid: capture rdata into o_rdata and rresp into o_resp, drop rready, go to DONE.
- DONE:
  - o_done=1 for one cycle; o_busy=0 in the same cycle; return to IDLE.
  - A new i_start is accepted in the cycle after DONE.
- Minimum latency (zero-wait slave):
  - Write: start to o_done is 4 cycles.
  - Read: start to o_done is 4 cycles.
- Valid never deasserts without a handshake (AXI rule), except on reset or timeout.
- Write path: o_rdata is left unchanged.

Optional Feature:
- Macro AXI4_LITE_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entering each wait state (WR, WR_RESP, RD_ADDR, RD_DATA) and increments every cycle in that state.
  - At G_TIMEOUT_CYCLES-1 all valid/ready outputs drop and the block goes to DONE with o_resp=2'b10 (SLVERR) and o_timeout=1.
  - A handshake in the expiry cycle takes priority: normal completion, no timeout.
- Undefined: no counter, o_timeout tied 0, the block waits indefinitely.

Decomposition:
- Package axi4_lite_pkg holds:
  - Response constants: C_RESP_OKAY=2'b00, C_RESP_EXOKAY=2'b01, C_RESP_SLVERR=2'b10, C_RESP_DECERR=2'b11.
  - C_AXI_PROT_DEFAULT=3'b000.
  - typedef enum t_axi_master_state {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE}.
- No sub-module. The watchdog is inline under the macro.

Test Plan:
- Zero-wait slave:
  - Stimulus: write addr 0x0000_0004, data 0x0000_0A55, wstrb 0xF.
  - Required: awvalid/wvalid high 1 cycle, o_done 4 cycles after start, o_resp=00, slave register holds 0x0A55.
- Backpressure:
  - Stimulus: awready delayed 3 cycles, wready delayed 6 cycles.
  - Required: awaddr/wdata stable while valid, each valid drops independently, o_done after bvalid.
- Read with a slow slave:
  - Stimulus: read addr 0x8, rvalid 5 cycles after arready, rdata 0xDEAD_BEEF, rresp 10.
  - Required: o_rdata=0xDEADBEEF and o_resp=10 on o_done.
- Busy and back-to-back:
  - Stimulus: i_start pulsed during a write, then again the cycle after o_done.
  - Required: the first extra start is ignored, the second is accepted (o_busy=1 next cycle).
- Reset mid-transaction:
  - Stimulus: rst_sys=1 while awvalid=1 and awready is held 0.
  - Required: the next cycle awvalid=0, o_busy=0, state IDLE, no o_done.
- Timeout, macro defined, G_TIMEOUT_CYCLES=16:
  - Stimulus: slave never asserts bvalid.
  - Required: o_done with o_timeout=1 and o_resp=10 after 16 cycles in WR_RESP.
